// File: rtl/cache_pkg.sv
// Shared encodings and address-split helpers for the set-associative cache controller.
package cache_pkg;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP, FLUSH} state_e;

  function automatic int tag_width(input int addr_w, input int offset_w, input int index_w);
    return addr_w - offset_w - index_w;
  endfunction

  function automatic int index_width(input int addr_w, input int offset_w, input int index_w);
    return (index_w < addr_w - offset_w) ? index_w : addr_w - offset_w;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set true-LRU helper: victim pick (lowest invalid way, else oldest) and the
// age update for touching one way.
module cache_lru #(
  parameter  int WAYS = 4,
  localparam int AW   = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][AW-1:0] age_i,
  input  logic [WAYS-1:0]         valid_i,
  input  logic [AW-1:0]           touch_i,
  output logic [AW-1:0]           victim_o,
  output logic [WAYS-1:0][AW-1:0] age_o
);

  logic [AW-1:0] touch_age;

  // Second loop runs high-to-low so the lowest invalid way overrides the oldest.
  always_comb begin
    victim_o = '0;
    for (int w = 0; w < WAYS; w++)
      if (age_i[w] == AW'(WAYS - 1)) victim_o = AW'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_i[w]) victim_o = AW'(w);
  end

  assign touch_age = age_i[touch_i];

  always_comb begin
    age_o = age_i;
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == touch_i)          age_o[w] = '0;
      else if (age_i[w] < touch_age)  age_o[w] = age_i[w] + AW'(1);
    end
  end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative tag/state controller with true-LRU replacement.
// Define CACHE_STATS_EN to build the saturating hit/miss counters.
module set_assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter  int ADDR_W      = 32,
  parameter  int OFFSET_W    = 2,
  parameter  int INDEX_W     = 8,
  parameter  int WAYS        = 4,
  parameter  int CNT_W       = 32,
  parameter  int STORE_ALLOC = 0,
  localparam int AW          = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  input  logic              stats_clr,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [AW-1:0]     rsp_way,
  output logic [CNT_W-1:0]  load_hit_cnt,
  output logic [CNT_W-1:0]  load_miss_cnt,
  output logic [CNT_W-1:0]  store_hit_cnt,
  output logic [CNT_W-1:0]  store_miss_cnt
);

  localparam int TAG_W = tag_width(ADDR_W, OFFSET_W, INDEX_W);
  localparam int IDX_W = index_width(ADDR_W, OFFSET_W, INDEX_W);
  localparam int SETS  = 1 << IDX_W;

  typedef logic [WAYS-1:0][AW-1:0] ages_t;

  function automatic ages_t age_reset();
    ages_t a;
    for (int w = 0; w < WAYS; w++) a[w] = AW'(w);
    return a;
  endfunction

  logic [WAYS-1:0][TAG_W-1:0] tags_q  [SETS];
  logic [WAYS-1:0]            valid_q [SETS];
  ages_t                      age_q   [SETS];

  state_e           state_q;
  logic             op_q, flush_pend_q, alloc_q;
  logic [TAG_W-1:0] req_tag_q;
  logic [IDX_W-1:0] idx_q, flush_idx_q;
  logic             rsp_valid_q, rsp_hit_q;
  logic [AW-1:0]    rsp_way_q;

  logic             hit, alloc_miss;
  logic [AW-1:0]    hit_way, victim;
  ages_t            age_upd;
  logic             unused_offset;

  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  assign req_ready = !rst && state_q == IDLE && !flush && !flush_pend_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_way   = rsp_way_q;

  assign alloc_miss = (op_q == OP_LOAD) || (STORE_ALLOC != 0 && op_q == OP_STORE);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[idx_q][w] && tags_q[idx_q][w] == req_tag_q) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
  end

  cache_lru #(.WAYS(WAYS)) u_lru (
    .age_i    (age_q[idx_q]),
    .valid_i  (valid_q[idx_q]),
    .touch_i  (rsp_way_q),
    .victim_o (victim),
    .age_o    (age_upd)
  );

  // Tags carry no reset: a line is only meaningful once its valid bit is set.
  always_ff @(posedge clk)
    if (state_q == RESP && alloc_q) tags_q[idx_q][rsp_way_q] <= req_tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_LOAD;
      req_tag_q    <= '0;
      idx_q        <= '0;
      flush_pend_q <= 1'b0;
      flush_idx_q  <= '0;
      alloc_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_way_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        age_q[s]   <= age_reset();
      end
    end else begin
      rsp_valid_q <= 1'b0;
      if (flush && state_q != IDLE && state_q != FLUSH) flush_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (flush || flush_pend_q) begin
            state_q      <= FLUSH;
            flush_pend_q <= 1'b0;
            flush_idx_q  <= '0;
          end else if (req_valid) begin
            op_q      <= req_op;
            req_tag_q <= req_addr[ADDR_W-1 -: TAG_W];
            idx_q     <= req_addr[OFFSET_W +: IDX_W];
            state_q   <= LOOKUP;
          end
        end
        LOOKUP: begin
          rsp_valid_q <= 1'b1;
          rsp_hit_q   <= hit;
          if (hit) begin
            rsp_way_q <= hit_way;
            alloc_q   <= 1'b0;
          end else if (alloc_miss) begin
            rsp_way_q <= victim;
            alloc_q   <= 1'b1;
          end else begin
            rsp_way_q <= '0;
            alloc_q   <= 1'b0;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_hit_q || alloc_q) begin
            valid_q[idx_q][rsp_way_q] <= 1'b1;
            age_q[idx_q]              <= age_upd;
          end
          if (flush || flush_pend_q) begin
            state_q      <= FLUSH;
            flush_pend_q <= 1'b0;
            flush_idx_q  <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        FLUSH: begin
          valid_q[flush_idx_q] <= '0;
          age_q[flush_idx_q]   <= age_reset();
          flush_idx_q          <= flush_idx_q + IDX_W'(1);
          if (flush_idx_q == IDX_W'(SETS - 1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Slot order: {store, miss} -> 0 load hit, 1 load miss, 2 store hit, 3 store miss.
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            cnt_sel;

  assign cnt_sel = {op_q == OP_STORE, !rsp_hit_q};

  always_comb begin
    cnt_d = cnt_q;
    if (stats_clr)
      cnt_d = '0;
    else if (state_q == RESP && !(&cnt_q[cnt_sel]))
      cnt_d[cnt_sel] = cnt_q[cnt_sel] + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;

  assign load_hit_cnt   = cnt_q[0];
  assign load_miss_cnt  = cnt_q[1];
  assign store_hit_cnt  = cnt_q[2];
  assign store_miss_cnt = cnt_q[3];
`else
  logic unused_clr;
  assign unused_clr     = stats_clr;
  assign load_hit_cnt   = '0;
  assign load_miss_cnt  = '0;
  assign store_hit_cnt  = '0;
  assign store_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench: two controllers (no store-allocate / 32-bit counters, and
// store-allocate / 4-bit counters) driven with identical stimulus.
module tb_set_assoc_cache_ctrl;

`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_op, flush, stats_clr;
  logic [31:0] req_addr;
  logic        rdy_a, rv_a, rh_a, rdy_b, rv_b, rh_b;
  logic [1:0]  rw_a, rw_b;
  logic [3:0][31:0] ca;
  logic [3:0][3:0]  cb;

  set_assoc_cache_ctrl #(.STORE_ALLOC(0), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a), .req_op(req_op),
    .req_addr(req_addr), .flush(flush), .stats_clr(stats_clr), .rsp_valid(rv_a),
    .rsp_hit(rh_a), .rsp_way(rw_a), .load_hit_cnt(ca[0]), .load_miss_cnt(ca[1]),
    .store_hit_cnt(ca[2]), .store_miss_cnt(ca[3]));

  set_assoc_cache_ctrl #(.STORE_ALLOC(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_b), .req_op(req_op),
    .req_addr(req_addr), .flush(flush), .stats_clr(stats_clr), .rsp_valid(rv_b),
    .rsp_hit(rh_b), .rsp_way(rw_b), .load_hit_cnt(cb[0]), .load_miss_cnt(cb[1]),
    .store_hit_cnt(cb[2]), .store_miss_cnt(cb[3]));

  int checks = 0;
  int errors = 0;
  int ea[4];
  int eb[4];

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic        ha;
    logic [1:0]  wa;
    logic        hb;
    logic [1:0]  wb;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_exp();
    for (int i = 0; i < 4; i++) begin ea[i] = 0; eb[i] = 0; end
  endtask

  task automatic bump(input logic op, input logic ha, input logic hb);
    int ia, ib;
    ia = int'({op, !ha});
    ib = int'({op, !hb});
    ea[ia] = ea[ia] + 1;
    eb[ib] = (eb[ib] < 15) ? eb[ib] + 1 : 15;
  endtask

  task automatic chk_counts(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_cnt_a%0d", tag, i), 64'(ca[i]), STATS ? 64'(ea[i]) : 64'd0);
      chk($sformatf("%s_cnt_b%0d", tag, i), 64'(cb[i]), STATS ? 64'(eb[i]) : 64'd0);
    end
  endtask

  // Entered just after a rising edge with the controllers idle; returns likewise.
  task automatic do_req(input string nm, input logic op, input logic [31:0] addr,
                        input logic eha, input logic [1:0] ewa,
                        input logic ehb, input logic [1:0] ewb, input logic clr_in_resp);
    req_op = op; req_addr = addr; req_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_idle"}, 64'({rdy_a, rdy_b, rv_a, rv_b}), 64'(4'b1100));
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_early"}, 64'({rv_a, rv_b}), 64'd0);
    @(negedge clk);
    chk({nm, "_rsp"}, 64'({rv_a, rh_a, rw_a, rv_b, rh_b, rw_b}),
        64'({1'b1, eha, ewa, 1'b1, ehb, ewb}));
    if (clr_in_resp) stats_clr = 1'b1;
    @(posedge clk); #1 stats_clr = 1'b0;
    bump(op, eha, ehb);
    if (clr_in_resp) clr_exp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, low;
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_addr = '0;
    flush = 1'b0; stats_clr = 1'b0;
    clr_exp();

    // set 0 = tags 0..4, then eviction, store policy, other sets
    vt[0]  = '{1'b0, 32'h0000, 1'b0, 2'd0, 1'b0, 2'd0};
    vt[1]  = '{1'b0, 32'h0400, 1'b0, 2'd1, 1'b0, 2'd1};
    vt[2]  = '{1'b0, 32'h0800, 1'b0, 2'd2, 1'b0, 2'd2};
    vt[3]  = '{1'b0, 32'h0C00, 1'b0, 2'd3, 1'b0, 2'd3};
    vt[4]  = '{1'b0, 32'h1000, 1'b0, 2'd0, 1'b0, 2'd0};
    vt[5]  = '{1'b0, 32'h0000, 1'b0, 2'd1, 1'b0, 2'd1};
    vt[6]  = '{1'b1, 32'h2000, 1'b0, 2'd0, 1'b0, 2'd2};
    vt[7]  = '{1'b0, 32'h2000, 1'b0, 2'd2, 1'b1, 2'd2};
    vt[8]  = '{1'b1, 32'h0C00, 1'b1, 2'd3, 1'b1, 2'd3};
    vt[9]  = '{1'b0, 32'h0004, 1'b0, 2'd0, 1'b0, 2'd0};
    vt[10] = '{1'b1, 32'h0008, 1'b0, 2'd0, 1'b0, 2'd0};
    vt[11] = '{1'b0, 32'h0008, 1'b0, 2'd0, 1'b1, 2'd0};
    vt[12] = '{1'b0, 32'h1000, 1'b1, 2'd0, 1'b1, 2'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp", 64'({rv_a, rh_a, rw_a, rv_b, rh_b, rw_b}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 64'({rdy_a, rdy_b}), 64'(2'b11));
    chk_counts("reset");
    @(posedge clk); #1;

    do_req("b0", 1'b0, 32'h0400, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    do_req("b1", 1'b0, 32'h0400, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0);
    chk_counts("basic");

    // reset while the request sits in LOOKUP: no response may follow
    req_op = 1'b0; req_addr = 32'h0400; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (rv_a || rv_b) pulses++;
    end
    chk("rst_mid_pulses", 64'(pulses), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    clr_exp();
    chk_counts("rst_mid");
    do_req("rm", 1'b0, 32'h0400, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clr_exp();
    for (int i = 0; i < 13; i++)
      do_req($sformatf("v%0d", i), vt[i].op, vt[i].addr, vt[i].ha, vt[i].wa,
             vt[i].hb, vt[i].wb, 1'b0);
    chk_counts("table");

    // flush raised during LOOKUP is latched; a second pulse mid-flush is ignored
    req_op = 1'b0; req_addr = 32'h0400; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("fl_rsp", 64'({rv_a, rh_a, rw_a, rv_b, rh_b, rw_b}),
        64'({1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd1}));
    bump(1'b0, 1'b0, 1'b0);
    low = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rdy_a && rdy_b) break;
      low++;
      flush = (i == 10);
    end
    flush = 1'b0;
    chk("flush_len", 64'(low), 64'd256);
    chk_counts("flush");
    @(posedge clk); #1;
    do_req("pf0", 1'b0, 32'h0400, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    do_req("pf1", 1'b0, 32'h1000, 1'b0, 2'd1, 1'b0, 2'd1, 1'b0);
    chk_counts("post_flush");

    // clear in the same cycle as an increment: clear wins
    do_req("clr_win", 1'b0, 32'h1000, 1'b1, 2'd1, 1'b1, 2'd1, 1'b1);
    chk_counts("clr_win");

    for (int i = 0; i < 17; i++)
      do_req($sformatf("sat%0d", i), 1'b0, (32'(i) << 10) | 32'h000C,
             1'b0, 2'(i % 4), 1'b0, 2'(i % 4), 1'b0);
    chk_counts("sat");

    stats_clr = 1'b1;
    @(posedge clk); #1 stats_clr = 1'b0;
    clr_exp();
    chk_counts("clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/set_assoc_cache_ctrl.md
Name: set_assoc_cache_ctrl

Overview:
- Synthesizable N-way set-associative cache tag/state controller that classifies load/store requests as hit or miss, with true-LRU replacement.
- Keeps saturating hit/miss statistics per operation type.
- Parametrised successor to the direct-mapped trace-driven hit/miss model: generalised ways, sets, address split and store policy, with flush and a request/response handshake.
- Sits between a trace/request driver and a statistics or data-array block; holds tags, valid bits and LRU state only, no data.

Parameters:
- ADDR_W, 32, request address width.
- OFFSET_W, 2, byte-offset bits, ignored for lookup.
- INDEX_W, 8, set-index bits; SETS = 2**INDEX_W.
- WAYS, 4, associativity; power of two, >= 2.
- CNT_W, 32, statistics counter width.
- STORE_ALLOC, 0, 1 = store miss allocates like a load; 0 = store miss is counted and nothing changes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_op  in  1  0 = load, 1 = store.
- req_addr  in  ADDR_W  byte address.
- flush  in  1  pulse; invalidates all lines.
- stats_clr  in  1  synchronous clear of all counters.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_hit  out  1  1 = hit, 0 = miss.
- rsp_way  out  log2(WAYS)  way hit or allocated; 0 on a non-allocating miss.
- load_hit_cnt, load_miss_cnt, store_hit_cnt, store_miss_cnt  out  CNT_W  statistics.

Behaviour:
- Address split: tag = addr[ADDR_W-1 : OFFSET_W+INDEX_W], index = addr[OFFSET_W+INDEX_W-1 : OFFSET_W].
- Reset (async):
  - FSM goes to IDLE; all valid bits cleared.
  - LRU age of way w in every set = w.
  - All counters 0; rsp_valid, rsp_hit, rsp_way = 0; req_ready = 1 once rst deasserts.
  - Reset mid-operation aborts the request; no response is issued.
- FSM states IDLE, LOOKUP, RESP, FLUSH.
  - IDLE: req_ready = 1 unless flush is pending. Handshake is req_valid & req_ready; op and address are registered and the FSM moves to LOOKUP.
  - LOOKUP: req_ready = 0. Compare the registered tag against all ways of the set. Hit = valid & tag equal; only one way can match.
  - Victim selection: lowest-index invalid way; else the way with age WAYS-1.
  - RESP: rsp_valid = 1 for exactly one cycle. Arrays, LRU and counters update on the same edge. FSM returns to IDLE, or to FLUSH if a flush is pending.
  - Latency: accept at edge N, rsp_valid high in cycle N+2. Peak throughput is one request per 3 cycles.
- Load miss: write tag to the victim, set valid, victim becomes MRU.
- Store hit: updates LRU only.
- Store miss:
  - STORE_ALLOC = 1: handled like a load miss.
  - STORE_ALLOC = 0: no state change, rsp_way = 0.
- LRU update on touch of way t with old age a: t gets age 0; every way with age < a increments. Ages stay a permutation of 0..WAYS-1.
- flush:
  - Latched if it arrives outside IDLE; it takes priority over req_valid in IDLE.
  - FLUSH state clears one set per cycle (valid = 0, ages reset to way index) for SETS cycles with req_ready = 0, then returns to IDLE.
  - A flush pulse during FLUSH is ignored.
  - Counters are unaffected by flush.
- Counters:
  - Increment by one in RESP only, saturating at all-ones.
  - stats_clr zeroes all counters. If stats_clr and an increment occur in the same cycle, the clear wins.

Optional Feature:
- CACHE_STATS_EN defined: the four counters and stats_clr behave as above.
- Not defined: no counter registers are built; all count outputs are tied to 0 and stats_clr is ignored. Hit/miss responses are unchanged.

Decomposition:
- Package cache_pkg holds:
  - op encoding constants OP_LOAD = 0, OP_STORE = 1;
  - FSM state enum;
  - helper functions for tag/index width from ADDR_W, OFFSET_W, INDEX_W.
- One sub-module, cache_lru: combinational per-set age update and victim select, parametrised by WAYS.
- Tag, valid and age storage stay in set_assoc_cache_ctrl.

Test Plan (defaults unless stated):
- After reset, load 0x400 then load 0x400 -> first rsp_hit = 0, way 0; second rsp_hit = 1, way 0; load_miss_cnt = 1, load_hit_cnt = 1. rsp_valid is 2 cycles after each accept.
- Loads to 0x0000, 0x0400, 0x0800, 0x0C00, 0x1000 (set 0, tags 0..4) -> five misses on ways 0, 1, 2, 3, 0. Then load 0x0000 -> miss on way 1 (evicts tag 1).
- STORE_ALLOC = 0: store 0x2000 -> miss, rsp_way = 0, store_miss_cnt = 1; then load 0x2000 -> miss. Repeat with STORE_ALLOC = 1 -> the load hits.
- Fill set 0, pulse flush -> req_ready low 256 cycles, then load 0x0400 -> miss; counters retain their pre-flush values.
- CNT_W = 4 with CACHE_STATS_EN: 17 load misses -> load_miss_cnt = 15. Pulse stats_clr -> 0. Without the macro, all counts stay 0.
- Assert rst during LOOKUP -> no rsp_valid pulse. After release, load of the previously hit address misses and all counters read 0.
